// File: rtl/reg_wr_pkg.sv
// Shared widths and requester indices for the register-file write arbiter.
package reg_wr_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        REQ_ALU  = 1'b0,
        REQ_LOAD = 1'b1
    } req_idx_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin on contention (or fixed priority to requester 0),
// one-hot combinational grant, last winner remembered across accepts.
module rr_arb2
    import reg_wr_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [1:0] Valid,
    input  logic       Accept,
    input  logic       PrioRR,
    output logic [1:0] Gnt
);

    req_idx_e last_gnt;

    // Reset value of LOAD makes the ALU requester win the first contention.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            last_gnt <= REQ_LOAD;
        end else if (Accept) begin
            last_gnt <= Gnt[1] ? REQ_LOAD : REQ_ALU;
        end
    end

    always_comb begin
        Gnt = 2'b00;
        if (Reset_n) begin
            case (Valid)
                2'b01:   Gnt = 2'b01;
                2'b10:   Gnt = 2'b10;
                2'b11:   Gnt = (PrioRR && (last_gnt == REQ_ALU)) ? 2'b10 : 2'b01;
                default: Gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Arbitrates ALU and load writebacks onto one register-file write port and
// keeps a pending-write scoreboard for issue-stage hazard checks.
module reg_wr_arbiter
    import reg_wr_pkg::*;
#(
    parameter bit PRIO_RR = 1'b1
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Req0Valid,
    input  logic [REG_ADDR_W-1:0] Req0RD,
    input  logic [REG_DATA_W-1:0] Req0WData,
    output logic                  Req0Ready,
    input  logic                  Req1Valid,
    input  logic [REG_ADDR_W-1:0] Req1RD,
    input  logic [REG_DATA_W-1:0] Req1WData,
    output logic                  Req1Ready,
    input  logic                  AllocValid,
    input  logic [REG_ADDR_W-1:0] AllocRD,
    input  logic [REG_ADDR_W-1:0] RS1,
    input  logic [REG_ADDR_W-1:0] RS2,
    output logic                  Busy1,
    output logic                  Busy2,
    output logic [REG_ADDR_W-1:0] RD,
    output logic [REG_DATA_W-1:0] WData,
    output logic                  RegWr
);

    logic [1:0]            gnt;
    logic                  accept;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [REG_DATA_W-1:0] sel_wdata;
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_nxt;

    rr_arb2 u_arb (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Valid   ({Req1Valid, Req0Valid}),
        .Accept  (accept),
        .PrioRR  (PRIO_RR),
        .Gnt     (gnt)
    );

    // Grants are already gated by Valid, so any grant is an accept.
    assign Req0Ready = gnt[REQ_ALU];
    assign Req1Ready = gnt[REQ_LOAD];
    assign accept    = |gnt;
    assign sel_rd    = gnt[REQ_LOAD] ? Req1RD    : Req0RD;
    assign sel_wdata = gnt[REQ_LOAD] ? Req1WData : Req0WData;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            RegWr <= 1'b0;
            RD    <= '0;
            WData <= '0;
        end else begin
            RegWr <= accept && (sel_rd != '0);
            if (accept) begin
                RD    <= sel_rd;
                WData <= sel_wdata;
            end
        end
    end

    // Clear first, then set, so a coincident allocate keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        if (RegWr) begin
            busy_nxt[RD] = 1'b0;
        end
        if (AllocValid && (AllocRD != '0)) begin
            busy_nxt[AllocRD] = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign Busy1 = (RS1 != '0) && busy[RS1];
    assign Busy2 = (RS2 != '0) && busy[RS2];

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Self-checking bench: round-robin and fixed-priority instances share stimulus
// and are compared every cycle against a behavioural model.
module tb_reg_wr_arbiter;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Req0Valid = 1'b0, Req1Valid = 1'b0, AllocValid = 1'b0;
    logic [4:0]  Req0RD = '0, Req1RD = '0, AllocRD = '0, RS1 = '0, RS2 = '0;
    logic [31:0] Req0WData = '0, Req1WData = '0;

    logic        rdy0_rr, rdy1_rr, busy1_rr, busy2_rr, regwr_rr;
    logic        rdy0_fx, rdy1_fx, busy1_fx, busy2_fx, regwr_fx;
    logic [4:0]  rd_rr, rd_fx;
    logic [31:0] wd_rr, wd_fx;

    int checks = 0;
    int errors = 0;

    // model state, index 0 = round-robin instance, 1 = fixed-priority instance
    int          m_last [2];
    bit [31:0]   m_busy [2];
    bit          m_wr   [2];
    bit [4:0]    m_rd   [2];
    bit [31:0]   m_wd   [2];
    bit          m_known[2];
    int          n_last [2];
    bit [31:0]   n_busy [2];
    bit          n_wr   [2];
    bit [4:0]    n_rd   [2];
    bit [31:0]   n_wd   [2];
    bit          n_known[2];

    always #5 Clk = ~Clk;

    reg_wr_arbiter #(.PRIO_RR(1'b1)) u_rr (
        .Clk(Clk), .Reset_n(Reset_n),
        .Req0Valid(Req0Valid), .Req0RD(Req0RD), .Req0WData(Req0WData), .Req0Ready(rdy0_rr),
        .Req1Valid(Req1Valid), .Req1RD(Req1RD), .Req1WData(Req1WData), .Req1Ready(rdy1_rr),
        .AllocValid(AllocValid), .AllocRD(AllocRD), .RS1(RS1), .RS2(RS2),
        .Busy1(busy1_rr), .Busy2(busy2_rr), .RD(rd_rr), .WData(wd_rr), .RegWr(regwr_rr)
    );

    reg_wr_arbiter #(.PRIO_RR(1'b0)) u_fx (
        .Clk(Clk), .Reset_n(Reset_n),
        .Req0Valid(Req0Valid), .Req0RD(Req0RD), .Req0WData(Req0WData), .Req0Ready(rdy0_fx),
        .Req1Valid(Req1Valid), .Req1RD(Req1RD), .Req1WData(Req1WData), .Req1Ready(rdy1_fx),
        .AllocValid(AllocValid), .AllocRD(AllocRD), .RS1(RS1), .RS2(RS2),
        .Busy1(busy1_fx), .Busy2(busy2_fx), .RD(rd_fx), .WData(wd_fx), .RegWr(regwr_fx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_last[m]  = 1;
            m_busy[m]  = '0;
            m_wr[m]    = 1'b0;
            m_rd[m]    = '0;
            m_wd[m]    = '0;
            m_known[m] = 1'b1;
        end
    endtask

    // Winner from the rules: lone requester wins; on contention round-robin
    // picks the one that did not win last, fixed priority picks requester 0.
    function automatic int winner(input int m);
        if (Req0Valid && Req1Valid) return (m == 0) ? 1 - m_last[m] : 0;
        if (Req0Valid) return 0;
        if (Req1Valid) return 1;
        return -1;
    endfunction

    function automatic bit exp_busy(input int m, input logic [4:0] rs);
        return (rs != 0) && m_busy[m][rs];
    endfunction

    task automatic check_dut(input int m, input int w);
        string p;
        p = (m == 0) ? "rr" : "fix";
        check({p, " Req0Ready"}, (m == 0) ? rdy0_rr  : rdy0_fx,  32'(w == 0));
        check({p, " Req1Ready"}, (m == 0) ? rdy1_rr  : rdy1_fx,  32'(w == 1));
        check({p, " Busy1"},     (m == 0) ? busy1_rr : busy1_fx, 32'(exp_busy(m, RS1)));
        check({p, " Busy2"},     (m == 0) ? busy2_rr : busy2_fx, 32'(exp_busy(m, RS2)));
        check({p, " RegWr"},     (m == 0) ? regwr_rr : regwr_fx, 32'(m_wr[m]));
        if (m_known[m]) begin
            check({p, " RD"},    (m == 0) ? rd_rr : rd_fx, 32'(m_rd[m]));
            check({p, " WData"}, (m == 0) ? wd_rr : wd_fx, m_wd[m]);
        end
    endtask

    // One clock: check at the falling edge, advance the model across the rising edge.
    task automatic step();
        int w;
        bit [4:0] rd;
        @(negedge Clk);
        for (int m = 0; m < 2; m++) begin
            w = winner(m);
            check_dut(m, w);
            n_busy[m] = m_busy[m];
            if (m_wr[m]) n_busy[m][m_rd[m]] = 1'b0;
            if (AllocValid && AllocRD != 0) n_busy[m][AllocRD] = 1'b1;
            n_last[m] = m_last[m];
            n_wr[m] = 1'b0;
            n_rd[m] = m_rd[m];
            n_wd[m] = m_wd[m];
            n_known[m] = m_known[m];
            if (w >= 0) begin
                rd = (w == 1) ? Req1RD : Req0RD;
                n_last[m] = w;
                n_wr[m] = (rd != 0);
                n_rd[m] = rd;
                n_wd[m] = (w == 1) ? Req1WData : Req0WData;
                n_known[m] = (rd != 0);
            end
        end
        @(posedge Clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            m_last[m]  = n_last[m];
            m_busy[m]  = n_busy[m];
            m_wr[m]    = n_wr[m];
            m_rd[m]    = n_rd[m];
            m_wd[m]    = n_wd[m];
            m_known[m] = n_known[m];
        end
    endtask

    initial begin
        model_reset();
        // requests presented while in reset must not be granted
        Req0Valid = 1'b1; Req0RD = 5'd3; Req0WData = 32'h0000_0333;
        Req1Valid = 1'b1; Req1RD = 5'd4; Req1WData = 32'h0000_0444;
        @(negedge Clk);
        check_dut(0, -1);
        check_dut(1, -1);
        @(posedge Clk);
        #1 Reset_n = 1'b1;

        // contention for four cycles: rr grants 0,1,0,1; fixed grants 0 always
        for (int i = 0; i < 4; i++) step();
        Req1Valid = 1'b0;
        Req0Valid = 1'b0;
        step();
        step();

        // lone request, then idle so RD/WData hold with RegWr low
        Req0Valid = 1'b1; Req0RD = 5'd5; Req0WData = 32'h0000_1234;
        step();
        Req0Valid = 1'b0;
        step();
        check("rr RD after lone write", rd_rr, 32'd5);
        step();
        check("rr WData held", wd_rr, 32'h0000_1234);

        // scoreboard: allocate 7, clear it via a load write three cycles later
        AllocValid = 1'b1; AllocRD = 5'd7; RS1 = 5'd7; RS2 = 5'd0;
        step();
        AllocValid = 1'b0;
        step();
        step();
        Req1Valid = 1'b1; Req1RD = 5'd7; Req1WData = 32'hCAFE_0007;
        step();
        Req1Valid = 1'b0;
        step();
        step();
        check("rr Busy1 after clear of 7", busy1_rr, 32'd0);

        // allocate of 9 coinciding with the write of 9: set wins
        AllocValid = 1'b1; AllocRD = 5'd9; RS2 = 5'd9;
        step();
        AllocValid = 1'b0;
        Req0Valid = 1'b1; Req0RD = 5'd9; Req0WData = 32'h0000_0009;
        step();
        Req0Valid = 1'b0;
        AllocValid = 1'b1; AllocRD = 5'd9;
        step();
        AllocValid = 1'b0;
        step();
        check("rr Busy2 set wins over clear", busy2_rr, 32'd1);

        // write to register 0 is accepted but never reaches the register file
        Req0Valid = 1'b1; Req0RD = 5'd0; Req0WData = 32'hDEAD_0000;
        step();
        Req0Valid = 1'b0;
        step();
        step();

        // randomized traffic with a small register window to force collisions
        for (int i = 0; i < 300; i++) begin
            Req0Valid  = 1'($urandom_range(0, 1));
            Req1Valid  = 1'($urandom_range(0, 1));
            Req0RD     = 5'($urandom_range(0, 7));
            Req1RD     = 5'($urandom_range(0, 7));
            Req0WData  = $urandom;
            Req1WData  = $urandom;
            AllocValid = 1'($urandom_range(0, 1));
            AllocRD    = 5'($urandom_range(0, 7));
            RS1        = 5'($urandom_range(0, 7));
            RS2        = 5'($urandom_range(0, 7));
            step();
        end

        // reset pulse while a write is being presented: outputs clear without a clock
        Req0Valid = 1'b1; Req1Valid = 1'b0; Req0RD = 5'd6; Req0WData = 32'h6666_6666;
        AllocValid = 1'b1; AllocRD = 5'd6; RS1 = 5'd6; RS2 = 5'd6;
        step();
        Req0Valid = 1'b0; AllocValid = 1'b0;
        check("rr RegWr before reset pulse", regwr_rr, 32'd1);
        Reset_n = 1'b0;
        #1;
        model_reset();
        for (int m = 0; m < 2; m++) check_dut(m, -1);
        check("rr RD zero in reset", rd_rr, 32'd0);
        check("fix WData zero in reset", wd_fx, 32'd0);
        #1 Reset_n = 1'b1;

        // after reset requester 0 wins the first contention again
        Req0Valid = 1'b1; Req1Valid = 1'b1; Req0RD = 5'd3; Req1RD = 5'd4;
        for (int i = 0; i < 4; i++) step();
        Req0Valid = 1'b0; Req1Valid = 1'b0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
